// File: rtl/c499_key_sched_if.sv
// Request/response handshake bundle between a host and the c499 key scheduler.
// master = host side, slave = scheduler side.
interface c499_key_sched_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic [7:0]  req_chk;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    modport master (
        output req_valid, req_data, req_chk, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, req_chk, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/c499_key_sched.sv
// Serial key loader and request/response sequencer wrapped around the c499 corrector datapath.
// Optional `KEY_PARITY_EN: an even-parity bit follows the key on the serial line.
module c499_key_sched #(
    parameter int KEY_W  = 47,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_sdi,
    input  logic             key_sen,
    input  logic             key_commit,
    output logic [3:0]       key_p,
    output logic [KEY_W-5:0] key_x,
    output logic             key_valid,
    output logic             key_err,
    output logic [39:0]      dp_in,
    output logic             dp_en,
    input  logic [31:0]      dp_out,
    output logic             busy,
    c499_key_sched_if.slave  bus
);

`ifdef KEY_PARITY_EN
    localparam int SH_W = KEY_W + 1;
`else
    localparam int SH_W = KEY_W;
`endif
    localparam int CNT_W = $clog2(SH_W + 1);

    typedef enum logic [1:0] {ST_LOCKED, ST_IDLE, ST_SETTLE, ST_RESP} state_t;

    state_t            state_reg, state_next;
    logic [SH_W-1:0]   shadow_reg, shadow_next;
    logic [CNT_W-1:0]  shift_cnt_reg, shift_cnt_next, cnt_after;
    logic [KEY_W-1:0]  active_reg, active_next;
    logic              key_valid_reg, key_err_reg;
    logic [3:0]        settle_cnt_reg;
    logic [39:0]       dp_in_reg;
    logic              dp_en_reg;
    logic [31:0]       rsp_data_reg;
    logic              key_open, key_full, parity_ok, commit_good, err_set;
    logic              accept, capture, release_rsp;

    always_comb begin
        key_open    = (state_reg == ST_LOCKED) || (state_reg == ST_IDLE);
        shadow_next = shadow_reg;
        cnt_after   = shift_cnt_reg;
        // The shift lands before the commit test, so a commit on the last bit's cycle sees the full count.
        if (key_sen && key_open) begin
            shadow_next = {shadow_reg[SH_W-2:0], key_sdi};
            if (shift_cnt_reg != CNT_W'(SH_W))
                cnt_after = shift_cnt_reg + CNT_W'(1);
        end
        key_full = (cnt_after == CNT_W'(SH_W));
`ifdef KEY_PARITY_EN
        parity_ok   = ~^shadow_next;
        active_next = shadow_next[SH_W-1:1];
`else
        parity_ok   = 1'b1;
        active_next = shadow_next;
`endif
        commit_good    = key_commit && key_open && key_full && parity_ok;
        shift_cnt_next = (key_commit && key_open) ? '0 : cnt_after;
        err_set        = (key_sen && !key_open) || (key_commit && !commit_good);

        accept      = bus.req_valid && (state_reg == ST_IDLE);
        capture     = (state_reg == ST_SETTLE) && (settle_cnt_reg == 4'd1);
        release_rsp = (state_reg == ST_RESP) && bus.rsp_ready;

        state_next = state_reg;
        case (state_reg)
            ST_LOCKED: if (commit_good) state_next = ST_IDLE;
            ST_IDLE:   if (accept)      state_next = ST_SETTLE;
            ST_SETTLE: if (capture)     state_next = ST_RESP;
            ST_RESP:   if (release_rsp) state_next = ST_IDLE;
            default:                    state_next = ST_LOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= ST_LOCKED;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_reg     <= '0;
            shift_cnt_reg  <= '0;
            active_reg     <= '0;
            key_valid_reg  <= 1'b0;
            key_err_reg    <= 1'b0;
            settle_cnt_reg <= '0;
            dp_in_reg      <= '0;
            dp_en_reg      <= 1'b0;
            rsp_data_reg   <= '0;
        end else begin
            shadow_reg    <= shadow_next;
            shift_cnt_reg <= shift_cnt_next;
            if (commit_good) begin
                active_reg    <= active_next;
                key_valid_reg <= 1'b1;
            end
            if (err_set)
                key_err_reg <= 1'b1;
            if (accept) begin
                dp_in_reg      <= {bus.req_chk, bus.req_data};
                dp_en_reg      <= 1'b1;
                settle_cnt_reg <= 4'(SETTLE);
            end else if (state_reg == ST_SETTLE) begin
                settle_cnt_reg <= settle_cnt_reg - 4'd1;
            end
            if (capture)
                rsp_data_reg <= dp_out;
            if (release_rsp)
                dp_en_reg <= 1'b0;
        end
    end

    assign key_p         = active_reg[KEY_W-1:KEY_W-4];
    assign key_x         = active_reg[KEY_W-5:0];
    assign key_valid     = key_valid_reg;
    assign key_err       = key_err_reg;
    assign dp_in         = dp_in_reg;
    assign dp_en         = dp_en_reg;
    assign busy          = (state_reg == ST_SETTLE) || (state_reg == ST_RESP);
    assign bus.req_ready = (state_reg == ST_IDLE);
    assign bus.rsp_valid = (state_reg == ST_RESP);
    assign bus.rsp_data  = rsp_data_reg;

endmodule

// File: doc/c499_key_sched.md
C499_KEY_SCHED -- requirements
Module: c499_key_sched

Interface
REQ-001 SHALL have parameter KEY_W, default 47, meaning total key bits (4 mux-select + 43 XOR).
REQ-002 SHALL have parameter SETTLE, default 2, range 1-15, meaning datapath settle cycles.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 key_sdi  input  1  serial key bit.
REQ-006 key_sen  input  1  shift enable.
REQ-007 key_commit  input  1  one-cycle pulse that commits the shadow key.
REQ-008 key_p  output  4  active mux-select key, driving p4..p1.
REQ-009 key_x  output  43  active XOR key, driving X_43..X_1.
REQ-010 key_valid  output  1  active key loaded.
REQ-011 key_err  output  1  sticky key-load error.
REQ-012 req_valid / req_ready  input / output  1 / 1  request handshake.
REQ-013 req_data, req_chk  input  32, 8  data word and check byte.
REQ-014 dp_in  output  40  registered datapath operand {chk, data}.
REQ-015 dp_en  output  1  datapath enable, driving N137.
REQ-016 dp_out  input  32  corrected word from the datapath.
REQ-017 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-018 rsp_data  output  32  captured corrected word.
REQ-019 busy  output  1  state is neither LOCKED nor IDLE.

Function
REQ-020 SHALL have FSM states LOCKED, IDLE, SETTLE, RESP.
REQ-021 Key shift: key_sen=1 in LOCKED or IDLE SHALL shift the shadow register left, with key_sdi entering bit 0 (MSB first), and increment a shift counter that saturates at KEY_W.
REQ-022 key_sen=1 in SETTLE or RESP SHALL be ignored and SHALL set key_err.
REQ-023 Commit with shift count == KEY_W SHALL copy the shadow register to the active key ({key_p,key_x} = active[46:0]), set key_valid, clear the counter, and move LOCKED->IDLE.
REQ-024 Commit with shift count != KEY_W SHALL leave the active key unchanged, set key_err, and clear the counter.
REQ-025 Commit outside LOCKED/IDLE SHALL be ignored and SHALL set key_err.
REQ-026 Commit and key_sen in the same cycle: the shift is applied first, and the count is tested after the shift.
REQ-027 req_ready SHALL be 1 only in IDLE.
REQ-028 Accept (req_valid && req_ready) SHALL register dp_in={req_chk,req_data}, set dp_en=1, and enter SETTLE with counter=SETTLE.
REQ-029 In SETTLE the counter SHALL decrement each cycle; at count 1, dp_out is captured into rsp_data and the FSM enters RESP.
REQ-030 rsp_valid SHALL be 1 only in RESP, first asserted SETTLE+1 cycles after the accept edge.
REQ-031 rsp_valid && rsp_ready SHALL clear dp_en and return to IDLE; rsp_data holds until the next capture.
REQ-032 With rsp_ready low, RESP and rsp_data SHALL hold indefinitely.
REQ-033 A valid commit in IDLE that coincides with a req accept SHALL take effect, and the new key applies to that request.
REQ-034 dp_in SHALL hold its value between requests.

Reset
REQ-035 rst_n=0 at a clock edge SHALL force LOCKED, shadow/active key=0, counters=0, key_valid=0, key_err=0, dp_in=0, dp_en=0, rsp_valid=0, rsp_data=0, req_ready=0, busy=0.
REQ-036 Reset mid-transaction SHALL abandon the transaction with no rsp_valid, and a new key load is then required.
REQ-037 key_err SHALL clear only on reset.

Configuration
REQ-038 Macro KEY_PARITY_EN.
- Defined: the shadow register is KEY_W+1 bits and the commit condition needs count == KEY_W+1.
- Defined: the extra bit (last shifted, bit 0) SHALL make the total even parity; on parity mismatch, reject per REQ-024.
- Undefined: no parity bit, per REQ-021..024.

Verification
REQ-039 Shift 47 bits 0x5_5555_5555_5555 then commit -> key_valid=1, key_p=0xA, key_x=0x555_5555_5555, state IDLE.
REQ-040 Shift 46 bits then commit -> key_valid=0, key_err=1, key unchanged.
REQ-041 SETTLE=2, accept data=0x1234_5678, chk=0x3C, dp_out tied 0xDEAD_BEEF -> rsp_valid at accept+3, rsp_data=0xDEAD_BEEF, dp_in=0x3C_1234_5678.
REQ-042 rsp_ready low 10 cycles -> rsp_valid and rsp_data stable, req_ready=0; rsp_ready=1 -> IDLE next cycle, dp_en=0.
REQ-043 key_sen pulsed in SETTLE -> key_err=1, active key unchanged, response still delivered.
REQ-044 rst_n low in SETTLE -> next cycle LOCKED, all outputs 0, no rsp_valid.
